// File: rtl/reg_file_sb.sv
// Parametrised register file with two combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired zero register and a RAW scoreboard.
module reg_file_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int AW       = $clog2(NREGS),
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   A1,
   input  logic [AW-1:0]   A2,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   input  logic [AW-1:0]   A3,
   input  logic [XLEN-1:0] WD3,
   input  logic            WE3,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            busy1,
   output logic            busy2,
   output logic [AW:0]     busy_count
);

   logic [XLEN-1:0]  regs_reg [NREGS];
   logic [NREGS-1:0] busy_reg;
   logic [NREGS-1:0] busy_next;
   logic [AW:0]      busy_count_reg;
   logic [AW:0]      busy_count_next;

   logic wr_en;
   logic set_en;
   logic set_new;
   logic clr_eff;

   assign wr_en  = WE3 && !(ZERO_REG && (A3 == '0));
   assign set_en = issue_valid && !(ZERO_REG && (issue_rd == '0));

   // A set and a clear on the same register resolve to set: the newer producer owns it.
   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
         localparam logic [AW-1:0] IDX = AW'(gi);
         assign busy_next[gi] = (set_en && (issue_rd == IDX)) ? 1'b1 :
                                (WE3 && (A3 == IDX))          ? 1'b0 :
                                busy_reg[gi];
      end
   endgenerate

   // The counter tracks the net number of bits that actually flip this edge.
   assign set_new = set_en && !busy_reg[issue_rd];
   assign clr_eff = WE3 && busy_reg[A3] && !(set_en && (issue_rd == A3));
   assign busy_count_next = busy_count_reg + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_eff};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= '0;
         end
         busy_reg       <= '0;
         busy_count_reg <= '0;
      end else begin
         if (wr_en) begin
            regs_reg[A3] <= WD3;
         end
         busy_reg       <= busy_next;
         busy_count_reg <= busy_count_next;
      end
   end

   // Returns {busy, data} for one read port in zero / bypass / array priority order.
   function automatic logic [XLEN:0] read_port(input logic [AW-1:0] a);
      logic [XLEN:0] r;
      r = {busy_reg[a], regs_reg[a]};
      if (reset || (ZERO_REG && (a == '0))) begin
         r = '0;
      end else if (BYPASS && WE3 && (A3 == a)) begin
         r = {1'b0, WD3};
      end
      return r;
   endfunction

   assign {busy1, RD1} = read_port(A1);
   assign {busy2, RD2} = read_port(A2);
   assign busy_count   = busy_count_reg;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default-configured instance checked every cycle against a
// behavioural model, plus a 64-bit / 16-entry / no-bypass / no-zero instance.
module tb_reg_file_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default configuration
   logic        reset;
   logic [4:0]  a1, a2, a3, ird;
   logic [31:0] wd;
   logic        we, iv;
   logic [31:0] rd1, rd2;
   logic        b1, b2;
   logic [5:0]  cnt;

   reg_file_sb dut (
      .clk(clk), .reset(reset), .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
      .A3(a3), .WD3(wd), .WE3(we), .issue_valid(iv), .issue_rd(ird),
      .busy1(b1), .busy2(b2), .busy_count(cnt)
   );

   // sweep configuration
   logic        s_reset;
   logic [3:0]  s_a1, s_a2, s_a3, s_ird;
   logic [63:0] s_wd;
   logic        s_we, s_iv;
   logic [63:0] s_rd1, s_rd2;
   logic        s_b1, s_b2;
   logic [4:0]  s_cnt;

   reg_file_sb #(.XLEN(64), .NREGS(16), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_s (
      .clk(clk), .reset(s_reset), .A1(s_a1), .A2(s_a2), .RD1(s_rd1), .RD2(s_rd2),
      .A3(s_a3), .WD3(s_wd), .WE3(s_we), .issue_valid(s_iv), .issue_rd(s_ird),
      .busy1(s_b1), .busy2(s_b2), .busy_count(s_cnt)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model of the default instance ----------------
   logic [31:0] mreg  [32];
   bit          mbusy [32];
   bit          mvalid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            mreg[i]  <= '0;
            mbusy[i] <= 1'b0;
         end
         mvalid <= 1'b1;
      end else if (mvalid) begin
         if (we && a3 != 0) mreg[a3] <= wd;
         if (we) mbusy[a3] <= 1'b0;
         if (iv && ird != 0) mbusy[ird] <= 1'b1;   // issued later, so it wins a tie
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (reset || a == 0) return 32'h0;
      if (we && a3 == a) return wd;
      return mreg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (reset || a == 0) return 1'b0;
      if (we && a3 == a) return 1'b0;
      return mbusy[a];
   endfunction

   function automatic int popcount();
      int n = 0;
      for (int i = 0; i < 32; i++) if (mbusy[i]) n++;
      return n;
   endfunction

   always @(negedge clk) begin
      if (mvalid) begin
         chk("model_rd1",   64'(rd1), 64'(exp_rd(a1)));
         chk("model_rd2",   64'(rd2), 64'(exp_rd(a2)));
         chk("model_busy1", 64'(b1),  64'(exp_busy(a1)));
         chk("model_busy2", 64'(b2),  64'(exp_busy(a2)));
         chk("model_count", 64'(cnt), 64'(popcount()));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; iv = 1'b0; reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; a1 = '0; a2 = '0; a3 = '0; ird = '0; wd = '0; we = 1'b0; iv = 1'b0;
      s_reset = 1'b1; s_a1 = '0; s_a2 = '0; s_a3 = '0; s_ird = '0; s_wd = '0;
      s_we = 1'b0; s_iv = 1'b0;
      tick(); tick();
      reset = 1'b0; s_reset = 1'b0;
      #1 chk("reset_count", 64'(cnt), 64'd0);

      $display("scenario: reset clears r5");
      we = 1'b1; a3 = 5'd5; wd = 32'hDEADBEEF;
      tick(); idle(); a1 = 5'd5;
      #1 chk("r5_written", 64'(rd1), 64'hDEADBEEF);
      reset = 1'b1;
      #1 chk("rd1_forced_in_reset", 64'(rd1), 64'h0);
      tick(); reset = 1'b0;
      #1 chk("r5_after_reset", 64'(rd1), 64'h0);
      chk("count_after_reset", 64'(cnt), 64'd0);

      $display("scenario: same-cycle bypass on r3");
      we = 1'b1; a3 = 5'd3; wd = 32'h0000000D; a1 = 5'd3;
      #1 chk("bypass_rd1", 64'(rd1), 64'hD);
      tick(); idle();
      #1 chk("r3_stored", 64'(rd1), 64'hD);

      $display("scenario: zero register ignores write and issue");
      we = 1'b1; a3 = 5'd0; wd = 32'h00AA791D; iv = 1'b1; ird = 5'd0; a2 = 5'd0;
      #1 chk("zero_rd2_same", 64'(rd2), 64'h0);
      tick(); idle();
      #1 chk("zero_rd2", 64'(rd2), 64'h0);
      chk("zero_busy2", 64'(b2), 64'h0);
      chk("zero_count", 64'(cnt), 64'd0);

      $display("scenario: RAW on r11");
      iv = 1'b1; ird = 5'd11;
      tick(); idle(); a1 = 5'd11;
      #1 chk("raw_count", 64'(cnt), 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("raw_busy1_stall", 64'(b1), 64'h1);
         if (i < 2) tick();
      end
      we = 1'b1; a3 = 5'd11; wd = 32'h12345678;
      #1 chk("raw_wb_busy1", 64'(b1), 64'h0);
      chk("raw_wb_rd1", 64'(rd1), 64'h12345678);
      tick(); idle();
      #1 chk("raw_done_count", 64'(cnt), 64'd0);
      chk("raw_done_rd1", 64'(rd1), 64'h12345678);

      $display("scenario: set and clear on r7, then issue r8 + retire r7");
      iv = 1'b1; ird = 5'd7;
      tick();
      we = 1'b1; a3 = 5'd7; wd = 32'h77;
      tick(); idle(); a1 = 5'd7;
      #1 chk("r7_still_busy", 64'(b1), 64'h1);
      chk("r7_count", 64'(cnt), 64'd1);
      chk("r7_data", 64'(rd1), 64'h77);
      iv = 1'b1; ird = 5'd8; we = 1'b1; a3 = 5'd7; wd = 32'h70;
      tick(); idle(); a2 = 5'd8;
      #1 chk("swap_count", 64'(cnt), 64'd1);
      chk("swap_busy1_r7", 64'(b1), 64'h0);
      chk("swap_busy2_r8", 64'(b2), 64'h1);
      we = 1'b1; a3 = 5'd8; wd = 32'h88;
      tick(); idle();

      $display("scenario: reset mid-operation drops pending write");
      iv = 1'b1; ird = 5'd2;
      tick(); ird = 5'd4;
      tick(); iv = 1'b0;
      we = 1'b1; a3 = 5'd9; wd = 32'h55; reset = 1'b1;
      tick(); idle(); a1 = 5'd9; a2 = 5'd4;
      #1 chk("midrst_rd1", 64'(rd1), 64'h0);
      chk("midrst_busy2", 64'(b2), 64'h0);
      chk("midrst_count", 64'(cnt), 64'd0);

      $display("scenario: mixed traffic on r0..r7");
      for (int i = 0; i < 300; i++) begin
         reset = ($urandom_range(0, 39) == 0);
         we  = $urandom_range(0, 1) == 1;
         iv  = $urandom_range(0, 1) == 1;
         a1  = 5'($urandom_range(0, 7));
         a2  = 5'($urandom_range(0, 7));
         a3  = 5'($urandom_range(0, 7));
         ird = 5'($urandom_range(0, 7));
         wd  = $urandom;
         tick();
      end
      idle();

      $display("scenario: 64-bit, 16 regs, no bypass, no zero register");
      s_we = 1'b1; s_a3 = 4'd0; s_wd = 64'hFFFF_FFFF_FFFF_FFFF; s_a1 = 4'd0;
      #1 chk("sweep_r0_old", s_rd1, 64'h0);
      tick(); s_we = 1'b0;
      #1 chk("sweep_r0_new", s_rd1, 64'hFFFF_FFFF_FFFF_FFFF);
      for (int i = 0; i < 16; i++) begin
         s_iv = 1'b1; s_ird = 4'(i);
         tick();
      end
      s_iv = 1'b0;
      #1 chk("sweep_count_full", 64'(s_cnt), 64'd16);
      s_a1 = 4'd5; s_we = 1'b1; s_a3 = 4'd5; s_wd = 64'h1234;
      #1 chk("sweep_no_bypass_busy1", 64'(s_b1), 64'h1);
      tick(); s_we = 1'b0;
      #1 chk("sweep_retire_count", 64'(s_cnt), 64'd15);
      chk("sweep_retire_busy1", 64'(s_b1), 64'h0);
      chk("sweep_r5", s_rd1, 64'h1234);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
